// File: rtl/unidade_controle_rodadas.sv
// Round-based memory game controller: Moore FSM driving the round counter,
// play counter, play register and timeout counter of the datapath.
module unidade_controle_rodadas (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       fimRodada,
    input  logic       fimTotal,
    input  logic       fimT,
    output logic       zeraCL,
    output logic       contaCL,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       conta,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIO_RODADA  = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTOU    = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERROU      = 4'hE
    } estado_t;

    estado_t estado_q;
    estado_t estado_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = INICIAL;
        case (estado_q)
            INICIAL:        estado_d = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     estado_d = INICIO_RODADA;
            INICIO_RODADA:  estado_d = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                // A play made on the timeout cycle still counts.
                if (jogada_feita) begin
                    estado_d = REGISTRA;
                end else if (fimT) begin
                    estado_d = FIM_TIMEOUT;
                end else begin
                    estado_d = ESPERA_JOGADA;
                end
            end
            REGISTRA:       estado_d = COMPARACAO;
            COMPARACAO: begin
                if (!igual) begin
                    estado_d = FIM_ERROU;
                end else if (fimRodada && fimTotal) begin
                    estado_d = FIM_ACERTOU;
                end else if (fimRodada) begin
                    estado_d = PROXIMA_RODADA;
                end else begin
                    estado_d = PROXIMA_JOGADA;
                end
            end
            PROXIMA_JOGADA: estado_d = ESPERA_JOGADA;
            PROXIMA_RODADA: estado_d = INICIO_RODADA;
            FIM_ACERTOU:    estado_d = iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_TIMEOUT:    estado_d = iniciar ? PREPARACAO : FIM_TIMEOUT;
            FIM_ERROU:      estado_d = iniciar ? PREPARACAO : FIM_ERROU;
            default:        estado_d = INICIAL;
        endcase
    end

    always_comb begin
        zeraCL    = 1'b0;
        contaCL   = 1'b0;
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        conta     = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (estado_q)
            PREPARACAO: begin
                zeraCL = 1'b1;
                zeraC  = 1'b1;
                zeraR  = 1'b1;
            end
            INICIO_RODADA: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            ESPERA_JOGADA:  conta     = 1'b1;
            REGISTRA:       registraR = 1'b1;
            PROXIMA_JOGADA: contaC    = 1'b1;
            PROXIMA_RODADA: contaCL   = 1'b1;
            FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Directed bench for unidade_controle_rodadas with a small counter model
// standing in for the round/play counters of the datapath.
module tb_unidade_controle_rodadas;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       jogada_feita;
    logic       igual;
    logic       fimRodada;
    logic       fimTotal;
    logic       fimT;
    logic       zeraCL;
    logic       contaCL;
    logic       zeraC;
    logic       contaC;
    logic       zeraR;
    logic       registraR;
    logic       conta;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;

    int checks;
    int failures;
    int n_contacl;

    logic       modo;
    logic [4:0] cnt_rodada;
    logic [4:0] cnt_jogada;
    logic [10:0] ovec;

    unidade_controle_rodadas dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .jogada_feita (jogada_feita),
        .igual        (igual),
        .fimRodada    (fimRodada),
        .fimTotal     (fimTotal),
        .fimT         (fimT),
        .zeraCL       (zeraCL),
        .contaCL      (contaCL),
        .zeraC        (zeraC),
        .contaC       (contaC),
        .zeraR        (zeraR),
        .registraR    (registraR),
        .conta        (conta),
        .pronto       (pronto),
        .acertou      (acertou),
        .errou        (errou),
        .timeout      (timeout),
        .db_estado    (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Datapath counters reacting to the controller's commands.
    always @(posedge clock) begin
        if (zeraCL) cnt_rodada <= 5'd0;
        else if (contaCL) cnt_rodada <= cnt_rodada + 5'd1;
        if (zeraC) cnt_jogada <= 5'd0;
        else if (contaC) cnt_jogada <= cnt_jogada + 5'd1;
        if (contaCL) n_contacl++;
    end

    assign fimRodada = (cnt_jogada == cnt_rodada);
    assign fimTotal  = (cnt_rodada == (modo ? 5'd3 : 5'd15));

    assign ovec = {zeraCL, contaCL, zeraC, contaC, zeraR, registraR,
                   conta, pronto, acertou, errou, timeout};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        iniciar = 1'b0;
        jogada_feita = 1'b0;
        igual = 1'b1;
        fimT = 1'b0;
        modo = 1'b1;
        #12;
        checks++;
        if (db_estado !== 4'h0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", db_estado);
        end
        checks++;
        if (ovec !== 11'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", ovec);
        end
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (db_estado !== 4'h0) begin
            failures++;
            $display("FAIL idle_hold got=%h exp=0", db_estado);
        end
    endtask

    task automatic start_game();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        checks++;
        if (db_estado !== 4'h1 || ovec !== 11'b10101000000) begin
            failures++;
            $display("FAIL start_prep st=%h out=%b", db_estado, ovec);
        end
        tick();
        checks++;
        if (db_estado !== 4'h2 || ovec !== 11'b00101000000) begin
            failures++;
            $display("FAIL start_inicio st=%h out=%b", db_estado, ovec);
        end
        tick();
        checks++;
        if (db_estado !== 4'h3 || ovec !== 11'b00000010000) begin
            failures++;
            $display("FAIL start_espera st=%h out=%b", db_estado, ovec);
        end
    endtask

    task automatic test_full_game();
        logic [3:0] exp_res [10];
        exp_res = '{4'h7, 4'h6, 4'h7, 4'h6, 4'h6, 4'h7,
                    4'h6, 4'h6, 4'h6, 4'hA};
        modo = 1'b1;
        igual = 1'b1;
        n_contacl = 0;
        start_game();
        for (int p = 0; p < 10; p++) begin
            jogada_feita = 1'b1;
            tick();
            jogada_feita = 1'b0;
            checks++;
            if (db_estado !== 4'h4 || ovec !== 11'b00000100000) begin
                failures++;
                $display("FAIL play%0d_registra st=%h out=%b", p, db_estado, ovec);
            end
            tick();
            checks++;
            if (db_estado !== 4'h5 || ovec !== 11'b0) begin
                failures++;
                $display("FAIL play%0d_compara st=%h out=%b", p, db_estado, ovec);
            end
            tick();
            checks++;
            if (db_estado !== exp_res[p]) begin
                failures++;
                $display("FAIL play%0d_result got=%h exp=%h", p, db_estado, exp_res[p]);
            end
            if (exp_res[p] == 4'h6) begin
                checks++;
                if (ovec !== 11'b00010000000) begin
                    failures++;
                    $display("FAIL play%0d_contaC got=%b", p, ovec);
                end
                tick();
            end else if (exp_res[p] == 4'h7) begin
                checks++;
                if (ovec !== 11'b01000000000) begin
                    failures++;
                    $display("FAIL play%0d_contaCL got=%b", p, ovec);
                end
                tick();
                checks++;
                if (db_estado !== 4'h2) begin
                    failures++;
                    $display("FAIL play%0d_inicio got=%h exp=2", p, db_estado);
                end
                tick();
            end
            if (exp_res[p] != 4'hA) begin
                checks++;
                if (db_estado !== 4'h3) begin
                    failures++;
                    $display("FAIL play%0d_back got=%h exp=3", p, db_estado);
                end
            end
        end
        checks++;
        if (ovec !== 11'b00000001100) begin
            failures++;
            $display("FAIL win_outputs got=%b exp=00000001100", ovec);
        end
        checks++;
        if (n_contacl !== 3) begin
            failures++;
            $display("FAIL win_contaCL_count got=%0d exp=3", n_contacl);
        end
        tick();
        tick();
        checks++;
        if (db_estado !== 4'hA || acertou !== 1'b1) begin
            failures++;
            $display("FAIL win_hold st=%h acertou=%b", db_estado, acertou);
        end
    endtask

    task automatic test_wrong_play();
        modo = 1'b1;
        igual = 1'b1;
        start_game();
        jogada_feita = 1'b1;
        tick();
        jogada_feita = 1'b0;
        tick();
        tick();
        tick();
        tick();
        checks++;
        if (db_estado !== 4'h3) begin
            failures++;
            $display("FAIL wrong_round1 got=%h exp=3", db_estado);
        end
        igual = 1'b0;
        jogada_feita = 1'b1;
        tick();
        jogada_feita = 1'b0;
        tick();
        tick();
        checks++;
        if (db_estado !== 4'hE || ovec !== 11'b00000001010) begin
            failures++;
            $display("FAIL wrong_final st=%h out=%b", db_estado, ovec);
        end
        igual = 1'b1;
    endtask

    task automatic test_restart();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        checks++;
        if (db_estado !== 4'h1 || ovec !== 11'b10101000000) begin
            failures++;
            $display("FAIL restart_prep st=%h out=%b", db_estado, ovec);
        end
        tick();
        checks++;
        if (zeraCL !== 1'b0 || errou !== 1'b0 || pronto !== 1'b0) begin
            failures++;
            $display("FAIL restart_pulse zeraCL=%b errou=%b pronto=%b",
                     zeraCL, errou, pronto);
        end
        tick();
        checks++;
        if (db_estado !== 4'h3) begin
            failures++;
            $display("FAIL restart_espera got=%h exp=3", db_estado);
        end
    endtask

    task automatic test_timeout();
        iniciar = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (db_estado !== 4'h3 || conta !== 1'b1) begin
                failures++;
                $display("FAIL wait%0d st=%h conta=%b", i, db_estado, conta);
            end
        end
        iniciar = 1'b0;
        fimT = 1'b1;
        tick();
        fimT = 1'b0;
        checks++;
        if (db_estado !== 4'hD || ovec !== 11'b00000001001) begin
            failures++;
            $display("FAIL timeout_final st=%h out=%b", db_estado, ovec);
        end
        jogada_feita = 1'b1;
        tick();
        jogada_feita = 1'b0;
        checks++;
        if (db_estado !== 4'hD) begin
            failures++;
            $display("FAIL timeout_hold got=%h exp=D", db_estado);
        end
    endtask

    task automatic test_jogada_vs_fimT();
        start_game();
        jogada_feita = 1'b1;
        fimT = 1'b1;
        tick();
        jogada_feita = 1'b0;
        fimT = 1'b0;
        checks++;
        if (db_estado !== 4'h4 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL both_high st=%h timeout=%b exp st=4", db_estado, timeout);
        end
    endtask

    task automatic test_reset_mid_game();
        fimT = 1'b1;
        tick();
        fimT = 1'b0;
        checks++;
        if (db_estado !== 4'h5) begin
            failures++;
            $display("FAIL pre_reset got=%h exp=5", db_estado);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (db_estado !== 4'h0 || ovec !== 11'b0) begin
            failures++;
            $display("FAIL async_reset st=%h out=%b", db_estado, ovec);
        end
        #3;
        reset = 1'b0;
        iniciar = 1'b0;
        tick();
        tick();
        checks++;
        if (db_estado !== 4'h0 || ovec !== 11'b0) begin
            failures++;
            $display("FAIL post_reset_idle st=%h out=%b", db_estado, ovec);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        n_contacl = 0;
        test_reset();
        test_full_game();
        test_wrong_play();
        test_restart();
        test_timeout();
        test_jogada_vs_fimT();
        test_reset_mid_game();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
